// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state type, code-width helper and 4x4 legend lookup shared
// by the keypad scanner files.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Key face legend of a 4x4 pad; row 0 is the top row (1 2 3 A), row 3 the bottom (0 F E D).
  function automatic logic [3:0] hex_legend(input logic [3:0] code);
    logic [3:0] sym;
    case (code)
      4'd0:    sym = 4'h1;
      4'd1:    sym = 4'h2;
      4'd2:    sym = 4'h3;
      4'd3:    sym = 4'hA;
      4'd4:    sym = 4'h4;
      4'd5:    sym = 4'h5;
      4'd6:    sym = 4'h6;
      4'd7:    sym = 4'hB;
      4'd8:    sym = 4'h7;
      4'd9:    sym = 4'h8;
      4'd10:   sym = 4'h9;
      4'd11:   sym = 4'hC;
      4'd12:   sym = 4'h0;
      4'd13:   sym = 4'hF;
      4'd14:   sym = 4'hE;
      4'd15:   sym = 4'hD;
      default: sym = 4'h0;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive cycles with 'level' high; 'stable' flags
// the DEBOUNCE-th such cycle. 'restart' or a low level clears the count.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic restart,
  output logic stable
);
  localparam int CNTW = code_width(DEBOUNCE);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);

  logic [CNTW-1:0] cnt_d, cnt_q;

  // Next count; it parks at CNT_LAST so a long run never wraps
  always_comb begin
    cnt_d  = cnt_q;
    stable = 1'b0;
    if (restart || !level) begin
      cnt_d = {CNTW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      stable = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNTW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: one-hot column scanner with debounced press/release detection.
// Define KEYSCAN_SYNC_EN to pass the row inputs through a two-flop synchroniser.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ROWS-1:0]                  rows,
  output logic [COLS-1:0]                  cols,
  output logic [code_width(ROWS*COLS)-1:0] key_code,
  output logic                             key_valid,
  output logic                             key_held
);
  localparam int CW  = code_width(ROWS * COLS);
  localparam int CIW = code_width(COLS);
  localparam int RIW = code_width(ROWS);
  localparam int DWW = code_width(DWELL);
  localparam logic [CIW-1:0]  COL_LAST    = CIW'(COLS - 1);
  localparam logic [DWW-1:0]  DWELL_LAST  = DWW'(DWELL - 1);
  localparam logic [COLS-1:0] COL0_ONEHOT = {{(COLS-1){1'b0}}, 1'b1};

  logic [ROWS-1:0] rs;
  kp_state_e       state_d, state_q;
  logic [CIW-1:0]  col_d, col_q, col_next;
  logic [RIW-1:0]  row_d, row_q, row_pick;
  logic [DWW-1:0]  dwell_d, dwell_q;
  logic [COLS-1:0] cols_d, cols_q;
  logic [CW-1:0]   key_code_d, key_code_q;
  logic            key_valid_d, key_valid_q;
  logic            key_held_d, key_held_q;
  logic            row_level, db_level, db_restart, db_stable;

`ifdef KEYSCAN_SYNC_EN
  logic [ROWS-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser on the row sense lines
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {ROWS{1'b0}};
      sync2_q <= {ROWS{1'b0}};
    end else begin
      sync1_q <= rows;
      sync2_q <= sync1_q;
    end
  end
  assign rs = sync2_q;
`else
  assign rs = rows;
`endif

  assign col_next   = (col_q == COL_LAST) ? {CIW{1'b0}} : col_q + 1'b1;
  assign row_level  = rs[row_q];
  // The shared counter measures closure while confirming and opening while releasing
  assign db_level   = (state_q == RELEASE_DB) ? ~row_level : row_level;
  assign db_restart = (state_q == SCAN) || (state_q == HELD);

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .level   (db_level),
    .restart (db_restart),
    .stable  (db_stable)
  );

  // Lowest-index closed row wins
  always_comb begin
    row_pick = {RIW{1'b0}};
    for (int i = ROWS - 1; i >= 0; i--) begin
      row_pick = rs[i] ? RIW'(i) : row_pick;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else if (rs != {ROWS{1'b0}}) begin
          row_d   = row_pick;
          dwell_d = {DWW{1'b0}};
          state_d = PRESS_DB;
        end else begin
          col_d   = col_next;
          dwell_d = {DWW{1'b0}};
        end
      end
      PRESS_DB: begin
        if (!row_level) begin
          col_d   = col_next;
          dwell_d = {DWW{1'b0}};
          state_d = SCAN;
        end else if (db_stable) begin
          key_code_d  = CW'(int'(row_q) * COLS + int'(col_q));
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          state_d = PRESS_DB;
        end
      end
      HELD: begin
        if (!row_level) begin
          state_d = RELEASE_DB;
        end else begin
          state_d = HELD;
        end
      end
      RELEASE_DB: begin
        if (row_level) begin
          state_d = HELD;
        end else if (db_stable) begin
          key_held_d = 1'b0;
          col_d      = {CIW{1'b0}};
          dwell_d    = {DWW{1'b0}};
          state_d    = SCAN;
        end else begin
          state_d = RELEASE_DB;
        end
      end
      default: begin
        col_d      = {CIW{1'b0}};
        dwell_d    = {DWW{1'b0}};
        key_held_d = 1'b0;
        state_d    = SCAN;
      end
    endcase
    cols_d = COL0_ONEHOT << col_d;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= {CIW{1'b0}};
      row_q       <= {RIW{1'b0}};
      dwell_q     <= {DWW{1'b0}};
      cols_q      <= COL0_ONEHOT;
      key_code_q  <= {CW{1'b0}};
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      cols_q      <= cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and random key presses on a 4x4 and a 2x3 keypad_scan,
// checked every cycle against a sequential scan/debounce model.
module tb_keypad_scan;
  import keypad_pkg::*;

`ifdef KEYSCAN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys_a = 16'h0;
  logic [5:0]  keys_b = 6'h0;
  logic [3:0]  rows_a, cols_a, key_code_a;
  logic [1:0]  rows_b;
  logic [2:0]  cols_b, key_code_b;
  logic        key_valid_a, key_held_a, key_valid_b, key_held_b;

  int exp_cols[2], exp_code[2];
  bit exp_valid[2], exp_held[2];
  int n_vec = 0, n_err = 0, pulses_a = 0, pulses_b = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  keypad_scan dut_a (
    .clk(clk), .reset(reset), .rows(rows_a), .cols(cols_a),
    .key_code(key_code_a), .key_valid(key_valid_a), .key_held(key_held_a));

  keypad_scan #(.ROWS(2), .COLS(3), .DWELL(8), .DEBOUNCE(4)) dut_b (
    .clk(clk), .reset(reset), .rows(rows_b), .cols(cols_b),
    .key_code(key_code_b), .key_valid(key_valid_b), .key_held(key_held_b));

  // Physical matrix: a pressed key closes its row only while its column is driven
  always_comb begin
    rows_a = 4'h0;
    rows_b = 2'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_a[r*4+c] && cols_a[c]) rows_a[r] = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        if (keys_b[r*3+c] && cols_b[c]) rows_b[r] = 1'b1;
  end

`ifdef KEYSCAN_SYNC_EN
  logic [3:0] sa1, sa2;
  logic [1:0] sb1, sb2;
  always @(posedge clk) begin
    if (reset) begin
      sa1 <= 4'h0; sa2 <= 4'h0; sb1 <= 2'h0; sb2 <= 2'h0;
    end else begin
      sa1 <= rows_a; sa2 <= sa1; sb1 <= rows_b; sb2 <= sb1;
    end
  end
  function automatic int sense(input int id);
    return (id == 0) ? int'(sa2) : int'(sb2);
  endfunction
`else
  function automatic int sense(input int id);
    return (id == 0) ? int'(rows_a) : int'(rows_b);
  endfunction
`endif

  function automatic int lowest(input int s, input int nr);
    for (int i = 0; i < nr; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sequential model: visit each column for dw cycles, confirm db closures, await db openings
  task automatic model(input int id, input int nr, input int nc, input int dw, input int db);
    int c, r, n, s;
    bit restart, ok;
    forever begin
      exp_cols[id] = 1; exp_code[id] = 0; exp_valid[id] = 0; exp_held[id] = 0;
      c = 0; restart = 0;
      while (!restart) begin
        s = 0;
        for (int k = 0; k < dw; k++) begin
          @(posedge clk);
          if (reset) begin restart = 1; break; end
          if (k == dw - 1) s = sense(id);
        end
        if (restart) break;
        if (s == 0) begin c = (c + 1) % nc; exp_cols[id] = 1 << c; continue; end
        r = lowest(s, nr);
        n = 0; ok = 0;
        while (1) begin
          @(posedge clk);
          if (reset) begin restart = 1; break; end
          s = sense(id);
          if (!s[r]) break;
          n++;
          if (n == db) begin ok = 1; break; end
        end
        if (restart) break;
        if (!ok) begin c = (c + 1) % nc; exp_cols[id] = 1 << c; continue; end
        exp_code[id] = r * nc + c; exp_valid[id] = 1; exp_held[id] = 1;
        n = -1;
        while (1) begin
          @(posedge clk);
          if (reset) begin restart = 1; break; end
          exp_valid[id] = 0;
          s = sense(id);
          if (s[r]) n = -1;
          else if (n < 0) n = 0;
          else begin n++; if (n == db) break; end
        end
        if (restart) break;
        exp_held[id] = 0; c = 0; exp_cols[id] = 1;
      end
    end
  endtask

  initial begin
    fork
      model(0, 4, 4, 8, 16);
      model(1, 2, 3, 8, 4);
    join_none
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cols_a", int'(cols_a), exp_cols[0]);
      chk("code_a", int'(key_code_a), exp_code[0]);
      chk("valid_a", int'(key_valid_a), int'(exp_valid[0]));
      chk("held_a", int'(key_held_a), int'(exp_held[0]));
      chk("onehot_a", $countones(cols_a), 1);
      chk("cols_b", int'(cols_b), exp_cols[1]);
      chk("code_b", int'(key_code_b), exp_code[1]);
      chk("valid_b", int'(key_valid_b), int'(exp_valid[1]));
      chk("held_b", int'(key_held_b), int'(exp_held[1]));
      chk("onehot_b", $countones(cols_b), 1);
      if (key_valid_a) pulses_a++;
      if (key_valid_b) pulses_b++;
    end
  end

  task automatic wait_valid(input int id, input int max);
    int t = 0;
    bit f = 0;
    while (!f && t < max) begin
      @(negedge clk); t++;
      f = (id == 0) ? key_valid_a : key_valid_b;
    end
    if (!f) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int id, input int max);
    int t = 0;
    bit f = 0;
    while (!f && t < max) begin
      @(negedge clk); t++;
      f = (id == 0) ? !key_held_a : !key_held_b;
    end
    if (!f) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_cols_a(input int val);
    int t = 0;
    while (int'(cols_a) != val && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("wait_cols_timeout", int'(cols_a), val);
  endtask

  int p0, len;
  logic [15:0] ka;
  logic [5:0]  kb;

  initial begin
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("legend_9", int'(hex_legend(4'd9)), 8);
    chk("legend_3", int'(hex_legend(4'd3)), 10);
    chk("legend_13", int'(hex_legend(4'd13)), 15);
    chk("reset_cols_a", int'(cols_a), 1);

    // Idle scan: 8 cycles per column, both pads wrap
    reset = 1'b0;
    p0 = pulses_a + pulses_b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        chk("idle_cols_a", int'(cols_a), 1 << (((k + 1) / 8) % 4));
        chk("idle_cols_b", int'(cols_b), 1 << (((k + 1) / 8) % 3));
      end
    end
    chk("idle_pulses", pulses_a + pulses_b - p0, 0);

    // Key row 2 / column 1 held, then released
    p0 = pulses_a;
    keys_a[2*4+1] = 1'b1;
    wait_valid(0, 100);
    repeat (40) @(negedge clk);
    chk("k9_pulses", pulses_a - p0, 1);
    chk("k9_code", int'(key_code_a), 9);
    chk("k9_held", int'(key_held_a), 1);
    keys_a = 16'h0;
    for (int j = 1; j <= 17 + SYNC_LAT; j++) begin
      @(negedge clk);
      if (j == 16 + SYNC_LAT) chk("k9_held_last", int'(key_held_a), 1);
      if (j == 17 + SYNC_LAT) chk("k9_held_clear", int'(key_held_a), 0);
    end

    // Bouncing key row 0 / column 3
    p0 = pulses_a;
    wait_cols_a(8);
    repeat (6) @(negedge clk);
    keys_a[3] = 1'b1;
    repeat (5) @(negedge clk);
    keys_a[3] = 1'b0;
    @(negedge clk);
    keys_a[3] = 1'b1;
    chk("bounce_no_pulse", pulses_a - p0, 0);
    wait_valid(0, 100);
    repeat (5) @(negedge clk);
    chk("bounce_pulses", pulses_a - p0, 1);
    chk("bounce_code", int'(key_code_a), 3);
    keys_a = 16'h0;
    wait_idle(0, 100);

    // Rows 1 and 3 together on column 0: lower row wins
    p0 = pulses_a;
    keys_a[1*4+0] = 1'b1;
    keys_a[3*4+0] = 1'b1;
    wait_valid(0, 100);
    repeat (20) @(negedge clk);
    chk("multi_pulses", pulses_a - p0, 1);
    chk("multi_code", int'(key_code_a), 4);
    keys_a = 16'h0;
    wait_idle(0, 100);

    // Reset 10 cycles into press confirmation
    p0 = pulses_a;
    wait_cols_a(4);
    keys_a[2*4+2] = 1'b1;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cols", int'(cols_a), 1);
    chk("rst_held", int'(key_held_a), 0);
    chk("rst_pulses", pulses_a - p0, 0);
    reset = 1'b0;
    keys_a = 16'h0;
    @(negedge clk);
    chk("rst_after_cols", int'(cols_a), 1);

    // Small pad: row 1 / column 2
    p0 = pulses_b;
    keys_b[1*3+2] = 1'b1;
    wait_valid(1, 60);
    repeat (10) @(negedge clk);
    chk("b_pulses", pulses_b - p0, 1);
    chk("b_code", int'(key_code_b), 5);
    keys_b = 6'h0;
    wait_idle(1, 60);

    // Random presses, dropouts and occasional reset on both pads
    for (int it = 0; it < 150; it++) begin
      ka = 16'h0;
      kb = 6'h0;
      case ($urandom_range(0, 3))
        1, 2: begin
          ka[$urandom_range(0, 15)] = 1'b1;
          kb[$urandom_range(0, 5)] = 1'b1;
        end
        3: begin
          ka[$urandom_range(0, 15)] = 1'b1;
          ka[$urandom_range(0, 15)] = 1'b1;
          kb[$urandom_range(0, 5)] = 1'b1;
          kb[$urandom_range(0, 5)] = 1'b1;
        end
        default: ;
      endcase
      len = $urandom_range(1, 90);
      for (int t = 0; t < len; t++) begin
        keys_a = ($urandom_range(0, 15) == 0) ? 16'h0 : ka;
        keys_b = ($urandom_range(0, 15) == 0) ? 6'h0 : kb;
        reset  = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
    end
    reset = 1'b0;
    keys_a = 16'h0;
    keys_b = 6'h0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
